cam_capture: RTL and testbench

- Parametrised camera-capture front end. Samples an OV7670-style parallel port (pclk, vsync, href, 8-bit data) entirely in the CLK100MHZ domain.
- Assembles byte pairs into PIX_W-bit pixels and generates a linear frame-buffer write stream (waddr/wdata/wen) for the memory controller's camera port.
- Successor to the fixed 640x480 RGB444 camera path: adds runtime pixel-format select, 2x decimation, frame gating, and line/frame error reporting.

---
 rtl/cam_capture_pkg.sv | 36 +++
 rtl/cam_sync_edge.sv | 39 +++
 rtl/cam_capture.sv | 184 ++++++++++++++++++
 tb/tb_cam_capture.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture path.
// Holds the pixel-format codes, the capture FSM state encoding, the default
// frame geometry shared with the memory controller and VGA blocks, and the
// byte-pair to RGB444 packing function.
package cam_capture_pkg;

  // Default frame geometry (640x480, 19-bit linear frame-buffer address)
  localparam int CAM_H_RES  = 640;
  localparam int CAM_V_RES  = 480;
  localparam int CAM_ADDR_W = 19;

  // Runtime pixel-format codes; code 3 is reserved and behaves like RGB444
  localparam logic [1:0] FMT_RGB565 = 2'd0;
  localparam logic [1:0] FMT_RGB444 = 2'd1;
  localparam logic [1:0] FMT_YUVY   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } cam_state_e;

  // Packs the first/second byte of a pixel into 12-bit RGB444.
  // RGB565 keeps the top four bits of each channel; YUV grey replicates
  // the top nibble of the luma byte into all three channels.
  function automatic logic [11:0] pack_pixel(input logic [1:0] f,
                                             input logic [7:0] b0,
                                             input logic [7:0] b1);
    case (f)
      FMT_RGB565: pack_pixel = {b0[7:4], b0[2:0], b1[7], b1[4:1]};
      FMT_YUVY:   pack_pixel = {b0[7:4], b0[7:4], b0[7:4]};
      default:    pack_pixel = {b0[3:0], b1};
    endcase
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Multi-flop synchroniser with rising/falling edge detection for a single
// camera control line sampled in the system clock domain.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   d    - raw asynchronous input
//   q    - synchronised level
//   rise - one-cycle pulse when q goes 0->1
//   fall - one-cycle pulse when q goes 1->0
module cam_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              q_d;

  // Synchroniser chain plus one extra flop holding the previous synced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      q_d  <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      q_d  <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/cam_capture.sv
// OV7670-style camera capture front end, fully in the CLK100MHZ domain.
// Samples pclk/vsync/href/cam_data through synchronisers, assembles byte
// pairs into RGB444 pixels and emits a linear frame-buffer write stream.
// Ports:
//   CLK100MHZ, rst          - system clock, async active-high reset
//   enable                  - capture enable, sampled at frame start
//   fmt, decim              - pixel format / 2x decimation, latched per frame
//   pclk, vsync, href,
//   cam_data                - raw camera port
//   waddr, wdata, wen       - frame-buffer write port
//   frame_done, busy        - frame status
//   err_line, err_short     - sticky line-overrun / short-frame flags
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int H_RES       = CAM_H_RES,
  parameter int V_RES       = CAM_V_RES,
  parameter int ADDR_W      = CAM_ADDR_W,
  parameter int PIX_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        fmt,
  input  logic              decim,
  input  logic              pclk,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        cam_data,
  output logic [ADDR_W-1:0] waddr,
  output logic [PIX_W-1:0]  wdata,
  output logic              wen,
  output logic              frame_done,
  output logic              busy,
  output logic              err_line,
  output logic              err_short
);

  localparam int COL_W = $clog2(H_RES + 1);
  localparam int ROW_W = $clog2(V_RES + 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_RES);
  localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(V_RES);
  localparam logic [ADDR_W-1:0] LAST_FULL = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [ADDR_W-1:0] LAST_DEC  = ADDR_W'((H_RES / 2) * (V_RES / 2) - 1);

  cam_state_e state, state_nxt;

  logic ev, href_q, href_fall, vs_rise, vs_fall;
  logic pclk_q_unused, pclk_fall_unused, vs_q_unused, href_rise_unused;

  logic [SYNC_STAGES-1:0][7:0] data_sync;
  logic [7:0]                  data_q;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row, row_eol;
  logic              phase;
  logic [7:0]        byte0;
  logic [1:0]        fmt_l;
  logic              decim_l;
  logic              keep;
  logic [ADDR_W-1:0] addr_last;

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
    .clk(CLK100MHZ), .rst(rst), .d(pclk),
    .q(pclk_q_unused), .rise(ev), .fall(pclk_fall_unused)
  );

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
    .clk(CLK100MHZ), .rst(rst), .d(vsync),
    .q(vs_q_unused), .rise(vs_rise), .fall(vs_fall)
  );

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
    .clk(CLK100MHZ), .rst(rst), .d(href),
    .q(href_q), .rise(href_rise_unused), .fall(href_fall)
  );

  // Data byte goes through the same depth as the controls so that it lines
  // up with the synced href level on the pclk-rise cycle
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) data_sync <= '0;
    else     data_sync <= {data_sync[SYNC_STAGES-2:0], cam_data};
  end
  assign data_q = data_sync[SYNC_STAGES-1];

  // State register
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; with enable still high at end of frame we re-arm
  // straight away because that vsync rise is also the next frame's start
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_rise && enable) state_nxt = ARMED;
      ARMED:   if (vs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (vs_rise) state_nxt = enable ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == ACTIVE);
  end

  // Row count as it stands after any end-of-line in this cycle, so that a
  // coincident href fall is counted before the short-frame check
  always_comb begin
    row_eol = row;
    if (href_fall && row != ROW_MAX) row_eol = row + ROW_W'(1);
  end

  assign keep      = !decim_l || (!col[0] && !row[0]);
  assign addr_last = decim_l ? LAST_DEC : LAST_FULL;

  // Capture datapath: byte pairing, counters, write strobe and error flags
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      waddr      <= '0;
      wdata      <= '0;
      wen        <= 1'b0;
      frame_done <= 1'b0;
      err_line   <= 1'b0;
      err_short  <= 1'b0;
      col        <= '0;
      row        <= '0;
      phase      <= 1'b0;
      byte0      <= '0;
      fmt_l      <= FMT_RGB444;
      decim_l    <= 1'b0;
    end else begin
      wen        <= 1'b0;
      frame_done <= 1'b0;
      if (wen && waddr != addr_last) waddr <= waddr + ADDR_W'(1);

      case (state)
        ARMED: begin
          if (vs_fall) begin
            col     <= '0;
            row     <= '0;
            phase   <= 1'b0;
            waddr   <= '0;
            fmt_l   <= fmt;
            decim_l <= decim;
          end
        end
        ACTIVE: begin
          if (ev && href_q) begin
            if (!phase) begin
              byte0 <= data_q;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (col == COL_MAX) begin
                err_line <= 1'b1;
              end else begin
                col <= col + COL_W'(1);
                if (row != ROW_MAX && keep) begin
                  wen   <= 1'b1;
                  wdata <= pack_pixel(fmt_l, byte0, data_q);
                end
              end
            end
          end
          if (href_fall) begin
            row   <= row_eol;
            col   <= '0;
            phase <= 1'b0;
          end
          if (vs_rise) begin
            if (row_eol != ROW_MAX) err_short <= 1'b1;
            frame_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture on a 4x4 frame. Frames of random or
// directed pixels are driven through a behavioural camera model; the
// expected write stream and error flags are computed from the frame
// contents and compared against every DUT write.
module tb_cam_capture;

  localparam int H  = 4;
  localparam int V  = 4;
  localparam int AW = 5;

  logic          CLK100MHZ = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    fmt;
  logic          decim;
  logic          pclk;
  logic          vsync;
  logic          href;
  logic [7:0]    cam_data;
  logic [AW-1:0] waddr;
  logic [11:0]   wdata;
  logic          wen;
  logic          frame_done;
  logic          busy;
  logic          err_line;
  logic          err_short;

  int checks = 0;
  int passed = 0;
  int done_cycles = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [11:0]   exp_data_q[$];
  bit            err_line_exp  = 1'b0;
  bit            err_short_exp = 1'b0;

  int         n_lines;
  int         line_len[8];
  logic [7:0] pb0[8][8];
  logic [7:0] pb1[8][8];

  cam_capture #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .PIX_W(12), .SYNC_STAGES(2)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .rst(rst), .enable(enable), .fmt(fmt),
    .decim(decim), .pclk(pclk), .vsync(vsync), .href(href),
    .cam_data(cam_data), .waddr(waddr), .wdata(wdata), .wen(wen),
    .frame_done(frame_done), .busy(busy), .err_line(err_line),
    .err_short(err_short)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
  endtask

  // Expected pixel: upper four bits of each colour channel
  function automatic logic [11:0] modelPixel(input int f, input logic [7:0] b0,
                                             input logic [7:0] b1);
    int r, g, b;
    case (f)
      0: begin
        r = (b0 / 8) / 2;
        g = (((b0 % 8) * 8) + (b1 / 32)) / 4;
        b = (b1 % 32) / 2;
      end
      2: begin
        r = b0 / 16; g = r; b = r;
      end
      default: begin
        r = b0 % 16; g = b1 / 16; b = b1 % 16;
      end
    endcase
    return 12'(r * 256 + g * 16 + b);
  endfunction

  // Expected write stream for the frame currently held in pb0/pb1
  task automatic buildExpected(input int f, input bit dec);
    int a = 0;
    for (int r = 0; r < n_lines; r++)
      for (int c = 0; c < line_len[r]; c++) begin
        if (c >= H) err_line_exp = 1'b1;
        else if (r < V && (!dec || (r % 2 == 0 && c % 2 == 0))) begin
          exp_addr_q.push_back(AW'(a));
          exp_data_q.push_back(modelPixel(f, pb0[r][c], pb1[r][c]));
          a++;
        end
      end
    if (n_lines < V) err_short_exp = 1'b1;
  endtask

  // mode 0: constant bytes, 1: random, 2: second byte = raster index
  task automatic fillFrame(input int nl, input int len, input int mode,
                           input logic [7:0] c0, input logic [7:0] c1);
    n_lines = nl;
    for (int r = 0; r < 8; r++) begin
      line_len[r] = len;
      for (int c = 0; c < 8; c++) begin
        case (mode)
          0:       begin pb0[r][c] = c0; pb1[r][c] = c1; end
          1:       begin pb0[r][c] = 8'($urandom); pb1[r][c] = 8'($urandom); end
          default: begin pb0[r][c] = 8'h00; pb1[r][c] = 8'(r * H + c); end
        endcase
      end
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  // One camera pixel-clock period carrying one byte
  task automatic camTick(input logic h, input logic [7:0] d);
    pclk = 1'b0; href = h; cam_data = d;
    waitClks(3);
    pclk = 1'b1;
    waitClks(3);
  endtask

  // Drives one whole frame; enable is dropped mid-frame so the FSM returns
  // to idle after it, and fmt/decim are scrambled after they were latched
  task automatic applyStimulus(input int f, input bit dec, input bit en);
    if (en) buildExpected(f, dec);
    done_cycles = 0;
    enable = en; fmt = 2'(f); decim = dec;
    vsync = 1'b1; repeat (3) camTick(1'b0, 8'h00);
    vsync = 1'b0; repeat (2) camTick(1'b0, 8'h00);
    fmt = 2'($urandom_range(3)); decim = 1'($urandom_range(1)); enable = 1'b0;
    for (int r = 0; r < n_lines; r++) begin
      for (int c = 0; c < line_len[r]; c++) begin
        camTick(1'b1, pb0[r][c]);
        camTick(1'b1, pb1[r][c]);
      end
      repeat (2) camTick(1'b0, 8'h00);
      if (r == 0) checkOutput("busy mid-frame", busy, en);
    end
    vsync = 1'b1; repeat (3) camTick(1'b0, 8'h00);
    vsync = 1'b0; repeat (2) camTick(1'b0, 8'h00);
  endtask

  task automatic endOfFrame(input string tag, input bit en);
    checkOutput({tag, " frame_done pulses"}, done_cycles, en);
    checkOutput({tag, " busy"}, busy, 1'b0);
    checkOutput({tag, " err_line"}, err_line, err_line_exp);
    checkOutput({tag, " err_short"}, err_short, err_short_exp);
    checkOutput({tag, " missing writes"}, exp_addr_q.size(), 0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  // Write scoreboard and frame_done pulse counter
  always @(negedge CLK100MHZ) begin
    if (!rst) begin
      if (frame_done) done_cycles++;
      if (wen) begin
        if (exp_addr_q.size() == 0) checkOutput("spurious wen", wen, 1'b0);
        else begin
          checkOutput("waddr", waddr, exp_addr_q.pop_front());
          checkOutput("wdata", wdata, exp_data_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; fmt = 2'd1; decim = 1'b0;
    pclk = 1'b0; vsync = 1'b0; href = 1'b0; cam_data = 8'h00;
    waitClks(3);
    checkOutput("reset waddr", waddr, 0);
    checkOutput("reset wdata", wdata, 0);
    checkOutput("reset wen", wen, 0);
    checkOutput("reset frame_done", frame_done, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset err_line", err_line, 0);
    checkOutput("reset err_short", err_short, 0);
    rst = 1'b0;
    waitClks(2);

    $display("[TB] RGB444 constant frame");
    fillFrame(V, H, 0, 8'h0A, 8'hBC);
    applyStimulus(1, 1'b0, 1'b1);
    endOfFrame("rgb444", 1'b1);

    $display("[TB] RGB565 frame");
    fillFrame(V, H, 1, 8'h00, 8'h00);
    pb0[0][0] = 8'hF8; pb1[0][0] = 8'h1F;
    pb0[0][1] = 8'h07; pb1[0][1] = 8'hE0;
    applyStimulus(0, 1'b0, 1'b1);
    endOfFrame("rgb565", 1'b1);

    $display("[TB] decimated frame");
    fillFrame(V, H, 2, 8'h00, 8'h00);
    applyStimulus(1, 1'b1, 1'b1);
    endOfFrame("decim", 1'b1);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] random frame %0d", i);
      fillFrame(V + int'($urandom_range(1)), H, 1, 8'h00, 8'h00);
      applyStimulus(int'($urandom_range(3)), 1'($urandom_range(1)), 1'b1);
      endOfFrame("random", 1'b1);
    end

    $display("[TB] overlong line");
    fillFrame(V, H, 1, 8'h00, 8'h00);
    line_len[0] = 6;
    applyStimulus(1, 1'b0, 1'b1);
    endOfFrame("overlong", 1'b1);

    $display("[TB] short frame");
    fillFrame(1, H, 1, 8'h00, 8'h00);
    applyStimulus(2, 1'b0, 1'b1);
    endOfFrame("short", 1'b1);

    $display("[TB] reset mid-line");
    done_cycles = 0;
    enable = 1'b1; fmt = 2'd1; decim = 1'b0;
    vsync = 1'b1; repeat (3) camTick(1'b0, 8'h00);
    vsync = 1'b0; repeat (2) camTick(1'b0, 8'h00);
    exp_addr_q.push_back('0);
    exp_data_q.push_back(modelPixel(1, 8'h12, 8'h34));
    camTick(1'b1, 8'h12);
    camTick(1'b1, 8'h34);
    camTick(1'b1, 8'h56);
    checkOutput("pre-reset busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async waddr", waddr, 0);
    checkOutput("async wdata", wdata, 0);
    checkOutput("async wen", wen, 0);
    checkOutput("async frame_done", frame_done, 0);
    checkOutput("async busy", busy, 0);
    checkOutput("async err_line", err_line, 0);
    checkOutput("async err_short", err_short, 0);
    waitClks(2);
    href = 1'b0; enable = 1'b0;
    rst = 1'b0;
    err_line_exp = 1'b0; err_short_exp = 1'b0;
    waitClks(4);
    checkOutput("no partial frame_done", done_cycles, 0);
    checkOutput("first pixel before reset", exp_addr_q.size(), 0);

    fillFrame(V, H, 1, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, 1'b0);
    endOfFrame("disabled", 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
